// File: rtl/combo_sequence_checker_pkg.sv
// Shared types and helpers for the combination-lock sequence checker.
package combo_pkg;

  localparam int CODE_W      = 3;
  localparam logic [CODE_W-1:0] CODE_NONE = 3'b000;
  // Widest packed combination supported (7 digits of 3 bits).
  localparam int COMBO_MAX_W = 21;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  // Returns digit number idx of the packed combination; digit 0 sits in the top bits.
  function automatic logic [CODE_W-1:0] combo_digit(
    input logic [COMBO_MAX_W-1:0] combo,
    input int unsigned            digits,
    input logic [CODE_W-1:0]      idx
  );
    logic [COMBO_MAX_W-1:0] shifted;
    int unsigned            shamt;
    if (32'(idx) < digits) begin
      shamt = 32'd3 * (digits - 32'd1 - 32'(idx));
    end else begin
      shamt = 32'd0;
    end
    shifted = combo >> shamt;
    return shifted[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/combo_sequence_checker_if.sv
// Bundle of the button-code input, the clear request and the lock status outputs.
interface combo_sequence_checker_if;
  import combo_pkg::*;

  logic [CODE_W-1:0] code;
  logic              clear;
  logic              unlocked;
  logic              error;
  logic              locked_out;
  logic [2:0]        digit_count;
  logic [2:0]        tries_left;

  modport master (
    output code, clear,
    input  unlocked, error, locked_out, digit_count, tries_left
  );

  modport slave (
    input  code, clear,
    output unlocked, error, locked_out, digit_count, tries_left
  );
endinterface

// File: rtl/combo_sequence_checker_press_detect.sv
// Two-stage capture of the encoder code and rising-from-idle press detection.
// The first stage also brings the asynchronous code into the clock domain.
module press_detect
  import combo_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              press_o,
  output logic [CODE_W-1:0] press_code_o
);

  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_p_q;

  // Capture the code, then keep its previous value for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      code_q   <= CODE_NONE;
      code_p_q <= CODE_NONE;
    end else begin
      code_q   <= code_i;
      code_p_q <= code_q;
    end
  end

  // A press is only a move away from "no button"; sliding between buttons is not one.
  assign press_o      = (code_q != CODE_NONE) && (code_p_q == CODE_NONE);
  assign press_code_o = code_q;

endmodule

// File: rtl/combo_sequence_checker.sv
// Combination-lock sequence checker fed by a 4-button priority encoder.
// Optional feature macro: COMBO_ENTRY_TIMEOUT_EN (inactivity timeout that
// abandons a partial entry and relocks an open lock).
module combo_sequence_checker
  import combo_pkg::*;
#(
  parameter int unsigned           DIGITS         = 4,
  parameter logic [3*DIGITS-1:0]   COMBO          = 12'b011_001_100_010,
  parameter int unsigned           MAX_TRIES      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 50_000_000,
  parameter int unsigned           TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  combo_sequence_checker_if.slave  bus
);

  localparam int unsigned LOCK_W   = $clog2(LOCKOUT_CYCLES);
  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);
  localparam logic [2:0]  TRIES_RL = 3'(MAX_TRIES);

  logic              press_s;
  logic [CODE_W-1:0] press_code_s;
  logic [CODE_W-1:0] exp_digit_s;
  logic              mismatch_s;
  logic              timeout_s;

  state_e            state_q;
  logic [2:0]        digit_cnt_q;
  logic [2:0]        tries_q;
  logic              flag_q;
  logic              error_q;
  logic              unlocked_q;
  logic              locked_out_q;
  logic [LOCK_W-1:0] lock_cnt_q;

  press_detect u_press_detect (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .code_i       (bus.code),
    .press_o      (press_s),
    .press_code_o (press_code_s)
  );

  // Sticky mismatch including the digit being pressed right now.
  assign exp_digit_s = combo_digit(COMBO_MAX_W'(COMBO), DIGITS, digit_cnt_q);
  assign mismatch_s  = flag_q | (press_code_s != exp_digit_s);

`ifdef COMBO_ENTRY_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q;
  state_e            prev_state_q;

  // Idle counter: reload on a press or a state change, otherwise run down to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q       <= '0;
      prev_state_q <= ST_ENTRY;
    end else begin
      prev_state_q <= state_q;
      if (press_s || (state_q != prev_state_q)) begin
        idle_q <= IDLE_W'(TIMEOUT_CYCLES - 1);
      end else if (idle_q != '0) begin
        idle_q <= idle_q - IDLE_W'(1);
      end else begin
        idle_q <= idle_q;
      end
    end
  end

  assign timeout_s = (idle_q == '0);
`else
  assign timeout_s = 1'b0;
`endif

  // Main FSM: digit counting, attempt evaluation, lockout timing and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_ENTRY;
      digit_cnt_q  <= 3'd0;
      tries_q      <= TRIES_RL;
      flag_q       <= 1'b0;
      error_q      <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        ST_ENTRY: begin
          if (bus.clear) begin
            // Clear beats a coincident press; the attempt restarts, tries kept.
            digit_cnt_q <= 3'd0;
            flag_q      <= 1'b0;
          end else if (press_s) begin
            if (digit_cnt_q == LAST_IDX) begin
              digit_cnt_q <= 3'd0;
              flag_q      <= 1'b0;
              if (!mismatch_s) begin
                state_q    <= ST_OPEN;
                unlocked_q <= 1'b1;
                tries_q    <= TRIES_RL;
              end else if (tries_q > 3'd1) begin
                error_q <= 1'b1;
                tries_q <= tries_q - 3'd1;
              end else begin
                error_q      <= 1'b1;
                tries_q      <= 3'd0;
                state_q      <= ST_LOCKOUT;
                locked_out_q <= 1'b1;
                lock_cnt_q   <= LOCK_W'(LOCKOUT_CYCLES - 1);
              end
            end else begin
              digit_cnt_q <= digit_cnt_q + 3'd1;
              flag_q      <= mismatch_s;
            end
          end else if (timeout_s && (digit_cnt_q != 3'd0)) begin
            digit_cnt_q <= 3'd0;
            flag_q      <= 1'b0;
          end
        end
        ST_OPEN: begin
          // Any press here only relocks; it is never counted as a digit.
          if (bus.clear || press_s || timeout_s) begin
            state_q     <= ST_ENTRY;
            unlocked_q  <= 1'b0;
            digit_cnt_q <= 3'd0;
            flag_q      <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (lock_cnt_q == '0) begin
            state_q      <= ST_ENTRY;
            locked_out_q <= 1'b0;
            tries_q      <= TRIES_RL;
            digit_cnt_q  <= 3'd0;
            flag_q       <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
          end
        end
        default: begin
          state_q      <= ST_ENTRY;
          unlocked_q   <= 1'b0;
          locked_out_q <= 1'b0;
          digit_cnt_q  <= 3'd0;
          flag_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlocked    = unlocked_q;
  assign bus.error       = error_q;
  assign bus.locked_out  = locked_out_q;
  assign bus.digit_count = digit_cnt_q;
  assign bus.tries_left  = tries_q;

endmodule
